// File: rtl/scrambler_pkg.sv
// Shared defaults for the keystream scrambler datapath.
package scrambler_pkg;
    localparam int KEY_W      = 8;
    localparam int PIX_W      = 24;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 16;
endpackage : scrambler_pkg

// File: rtl/keystream_fifo.sv
// Synchronous keystream FIFO with push/pop/flush; flush wins over push and pop.
module keystream_fifo
    import scrambler_pkg::*;
#(
    parameter int W     = KEY_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // A pop frees the slot a same-cycle push needs, so push is allowed when full if popping.
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && (!full || pop_ok) && !flush;

    // Storage write; no reset needed because count/empty guard every read.
    // NOTE: the memory array is deliberately left out of the reset -- resetting it
    // would turn the RAM into a wide bank of resettable flops for no functional gain.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule : keystream_fifo

// File: rtl/keystream_pixel_mixer.sv
// XORs active pixels with buffered keystream bytes; 2-clk pipeline, vsync-aligned flush.
module keystream_pixel_mixer
    import scrambler_pkg::*;
#(
    parameter int PIX_W_P      = PIX_W,
    parameter int KEY_W_P      = KEY_W,
    parameter int FIFO_DEPTH_P = FIFO_DEPTH,
    parameter int CNT_W_P      = CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [KEY_W_P-1:0] ks_data,
    input  logic               ks_valid,
    output logic               ks_ready,
    input  logic [PIX_W_P-1:0] pix_in,
    input  logic               pix_de,
    input  logic               pix_hs,
    input  logic               pix_vs,
    output logic [PIX_W_P-1:0] pix_out,
    output logic               out_de,
    output logic               out_hs,
    output logic               out_vs,
    input  logic               clr_status,
    output logic               underflow_sticky,
    output logic [CNT_W_P-1:0] underflow_cnt
);
    localparam int NCH = PIX_W_P / KEY_W_P;

    logic               vs_prev;
    logic               vs_rise;
    logic               fifo_full;
    logic               fifo_empty;
    logic [KEY_W_P-1:0] fifo_head;
    logic               want_key;
    logic               pop;
    logic               underflow;
    logic [KEY_W_P-1:0] key;

    logic [PIX_W_P-1:0] s1_pix;
    logic [KEY_W_P-1:0] s1_key;
    logic               s1_de;
    logic               s1_hs;
    logic               s1_vs;

    assign vs_rise   = pix_vs && !vs_prev;
    assign want_key  = pix_de && enable && !vs_rise;
    assign pop       = want_key && !fifo_empty;
    assign underflow = want_key && fifo_empty;
    assign key       = pop ? fifo_head : '0;
    assign ks_ready  = !fifo_full;

    keystream_fifo #(
        .W     (KEY_W_P),
        .DEPTH (FIFO_DEPTH_P)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (ks_valid),
        .pop     (pop),
        .flush   (vs_rise),
        .wdata   (ks_data),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Previous vsync level for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vs_prev <= 1'b0;
        else          vs_prev <= pix_vs;
    end

    // Stage 1: capture pixel, syncs and the key chosen for this pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_pix <= '0;
            s1_key <= '0;
            s1_de  <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
        end else begin
            s1_pix <= pix_in;
            s1_key <= key;
            s1_de  <= pix_de;
            s1_hs  <= pix_hs;
            s1_vs  <= pix_vs;
        end
    end

    // Stage 2: apply the key to every channel and forward the syncs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_out <= '0;
            out_de  <= 1'b0;
            out_hs  <= 1'b0;
            out_vs  <= 1'b0;
        end else begin
            pix_out <= s1_pix ^ {NCH{s1_key}};
            out_de  <= s1_de;
            out_hs  <= s1_hs;
            out_vs  <= s1_vs;
        end
    end

    // Underflow status; a clear beats a coincident underflow, count saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underflow_sticky <= 1'b0;
            underflow_cnt    <= '0;
        end else if (clr_status) begin
            underflow_sticky <= 1'b0;
            underflow_cnt    <= '0;
        end else if (underflow) begin
            underflow_sticky <= 1'b1;
            if (underflow_cnt != '1) underflow_cnt <= underflow_cnt + CNT_W_P'(1);
        end
    end
endmodule : keystream_pixel_mixer
